// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// CALC  | WIDTH iterations of shift-add or shift-subtract
// FIX   | sign correction, HI/LO write, done pulse
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opd;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div;
  logic               neg_q;
  logic               rneg_q;
  logic               dz_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Signed ops work on magnitudes; unsigned ops take operands as-is.
  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  assign a_abs = a_neg ? -a : a;
  assign b_abs = b_neg ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opd : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend shifting out / quotient shifting in}.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opd};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  always_comb begin
    prod_fix = neg_q  ? -acc : acc;
    quo_fix  = neg_q  ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (dz_q) begin
        hi_fix = a_raw;
        lo_fix = {WIDTH{1'b1}};
      end else begin
        hi_fix = rem_fix;
        lo_fix = quo_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      acc      <= '0;
      opd      <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            is_div <= op[1];
            a_raw  <= a;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            dz_q   <= op[1] & (b == '0);
            opd    <= op[1] ? b_abs : a_abs;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          hi       <= hi_fix;
          lo       <= lo_fix;
          done     <= 1'b1;
          div_zero <= dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start32, hi_we32, lo_we32, busy32, done32, dz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wdata32, hi32, lo32;

  logic        start8, hi_we8, lo_we8, busy8, done8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wdata8, hi8, lo8;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
    .hi_we(hi_we32), .lo_we(lo_we32), .wdata(wdata32),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32));

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8));

  int checks = 0;
  int errors = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t m32, m8;
  logic [31:0] last_hi32 = '0, last_lo32 = '0;
  logic [7:0]  last_hi8 = '0, last_lo8 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done32) begin
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done32: got done=1 expected no done");
      end else begin
        m32 = q32.pop_front();
        chk("hi32", hi32, m32.hi);
        chk("lo32", lo32, m32.lo);
        chk("div_zero32", {31'b0, dz32}, {31'b0, m32.dz});
      end
    end else if (dz32) begin
      errors++;
      $display("FAIL dz32_without_done: got div_zero=1 expected 0");
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done8: got done=1 expected no done");
      end else begin
        m8 = q8.pop_front();
        chk("hi8", {24'b0, hi8}, m8.hi);
        chk("lo8", {24'b0, lo8}, m8.lo);
        chk("div_zero8", {31'b0, dz8}, {31'b0, m8.dz});
      end
    end else if (dz8) begin
      errors++;
      $display("FAIL dz8_without_done: got div_zero=1 expected 0");
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // inject>0: at that busy cycle, pulse start with new operands plus hi_we.
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz,
                       input int inject, input logic wlo);
    int n;
    exp_t e;
    @(negedge clk);
    start32 = 1'b1; op32 = o; a32 = x; b32 = y;
    lo_we32 = wlo; wdata32 = 32'hBEEF;
    e.hi = eh; e.lo = el; e.dz = edz;
    q32.push_back(e);
    @(posedge clk); #1;
    start32 = 1'b0; lo_we32 = 1'b0; a32 = $urandom; b32 = $urandom;
    chk("busy_after_start32", {31'b0, busy32}, 32'd1);
    chk("hold_hi32", hi32, last_hi32);
    chk("hold_lo32", lo32, last_lo32);
    n = 1;
    while (busy32 && n < 200) begin
      if (n == inject) begin
        start32 = 1'b1; op32 = 2'b10; a32 = 32'h1111; b32 = 32'h3;
        hi_we32 = 1'b1; wdata32 = 32'hAAAA;
      end
      @(posedge clk); #1;
      start32 = 1'b0; hi_we32 = 1'b0;
      if (busy32) n++;
    end
    chk("busy_cycles32", n, 32'd33);
    chk("done_at_fix32", {31'b0, done32}, 32'd1);
    last_hi32 = eh; last_lo32 = el;
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] eh, input logic [7:0] el, input logic edz);
    int n;
    exp_t e;
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    e.hi = {24'b0, eh}; e.lo = {24'b0, el}; e.dz = edz;
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    chk("hold_hi8", {24'b0, hi8}, {24'b0, last_hi8});
    chk("hold_lo8", {24'b0, lo8}, {24'b0, last_lo8});
    n = 1;
    while (busy8 && n < 200) begin
      @(posedge clk); #1;
      if (busy8) n++;
    end
    chk("busy_cycles8", n, 32'd9);
    chk("done_at_fix8", {31'b0, done8}, 32'd1);
    last_hi8 = eh; last_lo8 = el;
  endtask

  task automatic mt32(input logic hw, input logic lw, input logic [31:0] d);
    @(negedge clk);
    hi_we32 = hw; lo_we32 = lw; wdata32 = d;
    @(posedge clk); #1;
    hi_we32 = 1'b0; lo_we32 = 1'b0;
    chk("mt_no_done32", {31'b0, done32}, 32'd0);
    if (hw) last_hi32 = d;
    if (lw) last_lo32 = d;
    chk("mt_hi32", hi32, last_hi32);
    chk("mt_lo32", lo32, last_lo32);
  endtask

  initial begin
    rst_n = 1'b0;
    start32 = 0; op32 = 0; a32 = 0; b32 = 0; hi_we32 = 0; lo_we32 = 0; wdata32 = 0;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0; hi_we8 = 0; lo_we8 = 0; wdata8 = 0;
    #12;
    chk("rst_hi", hi32, 32'h0);
    chk("rst_lo", lo32, 32'h0);
    chk("rst_busy", {31'b0, busy32}, 32'd0);
    chk("rst_done", {31'b0, done32}, 32'd0);
    chk("rst_dz", {31'b0, dz32}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run32(2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 0, 1'b0);
    run32(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0, 1'b0);
    run32(2'b10, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 0, 1'b0);
    run32(2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 1'b0);
    run32(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0, 1'b0);
    run32(2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0, 1'b0);
    run32(2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 0, 1'b0);
    run32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 0, 1'b0);
    run32(2'b10, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
    run32(2'b00, 32'd2,        32'd3,        32'h00000000, 32'h00000006, 1'b0, 0, 1'b0);
    run32(2'b11, 32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
    run32(2'b00, 32'd7,        32'd9,        32'h00000000, 32'd63,       1'b0, 5, 1'b0);

    mt32(1'b1, 1'b0, 32'h0000AAAA);
    run32(2'b00, 32'd1,        32'd1,        32'h00000000, 32'h00000001, 1'b0, 0, 1'b1);
    mt32(1'b1, 1'b1, 32'h00000077);
    mt32(1'b1, 1'b0, 32'h00000055);
    mt32(1'b0, 1'b1, 32'h00000066);

    @(negedge clk);
    start32 = 1'b1; op32 = 2'b11; a32 = 32'hFFFFFF9C; b32 = 32'd3;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_hi", hi32, 32'h0);
    chk("abort_lo", lo32, 32'h0);
    chk("abort_busy", {31'b0, busy32}, 32'd0);
    chk("abort_done", {31'b0, done32}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_hi32 = '0; last_lo32 = '0;
    repeat (40) @(posedge clk);
    run32(2'b00, 32'd2,        32'd3,        32'h00000000, 32'h00000006, 1'b0, 0, 1'b0);

    run8(2'b01, 8'hFD, 8'h05, 8'hFF, 8'hF1, 1'b0);
    run8(2'b00, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0);
    run8(2'b10, 8'd100, 8'd7, 8'h02, 8'h0E, 1'b0);
    run8(2'b11, 8'hF9, 8'h02, 8'hFF, 8'hFD, 1'b0);
    run8(2'b11, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
    run8(2'b10, 8'h34, 8'h00, 8'h34, 8'hFF, 1'b1);
    run8(2'b00, 8'd2, 8'd3, 8'h00, 8'h06, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("q32_drained", q32.size(), 32'd0);
    chk("q8_drained", q8.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
